// File: rtl/ball_ctrl.sv
// ball_ctrl: Pong ball-motion engine.
// Moves the ball one pixel per axis on every prescaler tick, bounces it off
// the top/bottom walls and the paddle faces, and pulses a score output when
// the ball reaches a side wall. After a score the ball is frozen for
// HOLD_TICKS ticks, then recentred and parked until the next serve.
module ball_ctrl #(
   parameter int H_MAX      = 640,
   parameter int V_MAX      = 480,
   parameter int BALL_SIZE  = 8,
   parameter int PADDLE_H   = 64,
   parameter int PADDLE_W   = 8,
   parameter int PADDLE_X_L = 16,
   parameter int PADDLE_X_R = 616,
   parameter int TICK_DIV   = 18,
   parameter int HOLD_TICKS = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       serve,
   input  logic [9:0] lpad_y,
   input  logic [9:0] rpad_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic       in_play,
   output logic       score_l,
   output logic       score_r
);

   typedef enum logic [1:0] {IDLE, PLAY, SCORE} state_t;

   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   localparam logic [9:0]  X_CTR  = 10'((H_MAX - BALL_SIZE) / 2);
   localparam logic [9:0]  Y_CTR  = 10'((V_MAX - BALL_SIZE) / 2);
   localparam logic [10:0] BS     = 11'(BALL_SIZE);
   localparam logic [10:0] PH     = 11'(PADDLE_H);
   localparam logic [10:0] HMAX   = 11'(H_MAX);
   localparam logic [10:0] VMAX   = 11'(V_MAX);
   localparam logic [10:0] L_FACE = 11'(PADDLE_X_L + PADDLE_W);
   localparam logic [10:0] R_FACE = 11'(PADDLE_X_R);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

   state_t              state_q, state_d;
   logic [TICK_DIV-1:0] presc_q;
   logic                tick;
   logic [9:0]          lpad_q, rpad_q;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [9:0]          x_d, y_d;
   logic                dx_d, dy_d, sl_d, sr_d;
   logic [10:0]         x11, y11, lp11, rp11;
   logic                l_ovl, r_ovl;

   assign tick    = &presc_q;
   assign in_play = (state_q == PLAY);

   // 11-bit working copies so no sum below can wrap
   assign x11  = {1'b0, ball_x};
   assign y11  = {1'b0, ball_y};
   assign lp11 = {1'b0, lpad_q};
   assign rp11 = {1'b0, rpad_q};

   assign l_ovl = (y11 + BS > lp11) && (y11 < lp11 + PH);
   assign r_ovl = (y11 + BS > rp11) && (y11 < rp11 + PH);

   // Free-running prescaler; tick fires while it is all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) presc_q <= '0;
      else     presc_q <= presc_q + TICK_DIV'(1);
   end

   // Register paddle positions so tick decisions see stable values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lpad_q <= '0;
         rpad_q <= '0;
      end else begin
         lpad_q <= lpad_y;
         rpad_q <= rpad_y;
      end
   end

   // State, ball position, directions, hold counter and score pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ball_x  <= X_CTR;
         ball_y  <= Y_CTR;
         dir_x   <= 1'b1;
         dir_y   <= 1'b1;
         hold_q  <= '0;
         score_l <= 1'b0;
         score_r <= 1'b0;
      end else begin
         state_q <= state_d;
         ball_x  <= x_d;
         ball_y  <= y_d;
         dir_x   <= dx_d;
         dir_y   <= dy_d;
         hold_q  <= hold_d;
         score_l <= sl_d;
         score_r <= sr_d;
      end
   end

   // Next-state and motion logic; X and Y resolve independently each tick
   always_comb begin
      state_d = state_q;
      x_d     = ball_x;
      y_d     = ball_y;
      dx_d    = dir_x;
      dy_d    = dir_y;
      hold_d  = hold_q;
      sl_d    = 1'b0;
      sr_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            x_d = X_CTR;
            y_d = Y_CTR;
            if (serve) state_d = PLAY;
         end
         PLAY: begin
            if (tick) begin
               if (dir_y) begin
                  if (y11 + BS == VMAX) begin
                     dy_d = 1'b0;
                     y_d  = 10'(y11 - 11'd1);
                  end else begin
                     y_d  = 10'(y11 + 11'd1);
                  end
               end else begin
                  if (y11 == '0) begin
                     dy_d = 1'b1;
                     y_d  = 10'(y11 + 11'd1);
                  end else begin
                     y_d  = 10'(y11 - 11'd1);
                  end
               end
               if (!dir_x) begin
                  if (x11 == L_FACE && l_ovl) begin
                     dx_d = 1'b1;
                     x_d  = 10'(x11 + 11'd1);
                  end else if (x11 == '0) begin
                     sr_d    = 1'b1;
                     state_d = SCORE;
                     hold_d  = '0;
                  end else begin
                     x_d = 10'(x11 - 11'd1);
                  end
               end else begin
                  if (x11 + BS == R_FACE && r_ovl) begin
                     dx_d = 1'b0;
                     x_d  = 10'(x11 - 11'd1);
                  end else if (x11 + BS == HMAX) begin
                     sl_d    = 1'b1;
                     state_d = SCORE;
                     hold_d  = '0;
                  end else begin
                     x_d = 10'(x11 + 11'd1);
                  end
               end
            end
         end
         SCORE: begin
            if (tick) begin
               if (hold_q == HOLD_LAST) begin
                  // dir_x still points at the wall that was reached, i.e.
                  // toward the conceding player, so it is kept as is
                  state_d = IDLE;
                  x_d     = X_CTR;
                  y_d     = Y_CTR;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed self-checking bench for ball_ctrl.
// Ball positions are hand-derived from the tick count since the serve.
// A one-bit prescaler (tick every 2 clk) keeps the long paddle rally short.
module tb_ball_ctrl;

   localparam int TD = 1;
   localparam int HT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       serve;
   logic [9:0] lpad_y, rpad_y;
   logic [9:0] ball_x, ball_y;
   logic       dir_x, dir_y, in_play, score_l, score_r;

   logic [TD-1:0] pc;
   int nticks = 0;
   int base   = 0;
   int checks = 0;
   int errors = 0;

   ball_ctrl #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
      .clk     (clk),
      .rst     (rst),
      .serve   (serve),
      .lpad_y  (lpad_y),
      .rpad_y  (rpad_y),
      .ball_x  (ball_x),
      .ball_y  (ball_y),
      .dir_x   (dir_x),
      .dir_y   (dir_y),
      .in_play (in_play),
      .score_l (score_l),
      .score_r (score_r)
   );

   always #5 clk = ~clk;

   // Bench copy of the tick timing: counts clk edges since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) pc <= '0;
      else     pc <= pc + TD'(1);
   end

   // Running count of tick edges
   always @(posedge clk) begin
      if (!rst && pc == '1) nticks <= nticks + 1;
   end

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_ball(input string tag, input int x, input int y,
                             input int dx, input int dy);
      check_val({tag, "_x"},  int'(ball_x), x);
      check_val({tag, "_y"},  int'(ball_y), y);
      check_val({tag, "_dx"}, int'(dir_x),  dx);
      check_val({tag, "_dy"}, int'(dir_y),  dy);
   endtask

   // Advance to the negedge just after tick k (counted from the serve)
   task automatic run_to(input int k);
      int budget;
      budget = ((k - (nticks - base)) + 2) * (2 ** TD) + 4;
      while ((nticks - base) < k) begin
         if (budget <= 0) begin
            check_val("tick_timeout", nticks - base, k);
            return;
         end
         budget--;
         @(negedge clk);
      end
   endtask

   task automatic serve_ball();
      @(negedge clk);
      serve = 1'b1;
      @(negedge clk);
      serve = 1'b0;
      base  = nticks;
   endtask

   // Ball y for a serve with dir_y=1 from y=236 (triangle 0..472)
   function automatic int ytri(input int k);
      int u;
      u = (236 + k) % 944;
      return (u <= 472) ? u : 944 - u;
   endfunction

   // Paddle top that keeps the ball vertically overlapped
   function automatic int pad_for(input int y);
      if (y < 28)  return 0;
      if (y > 444) return 416;
      return y - 28;
   endfunction

   initial begin
      rst    = 1'b1;
      serve  = 1'b0;
      lpad_y = '0;
      rpad_y = '0;
      repeat (3) @(negedge clk);
      check_ball("reset", 316, 236, 1, 1);
      check_val("reset_in_play", int'(in_play), 0);
      check_val("reset_score_l", int'(score_l), 0);
      check_val("reset_score_r", int'(score_r), 0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_ball("idle_hold", 316, 236, 1, 1);
      check_val("idle_in_play", int'(in_play), 0);

      // Serve, first tick, then async reset mid-play
      serve_ball();
      check_val("serve_in_play", int'(in_play), 1);
      check_ball("serve_centre", 316, 236, 1, 1);
      run_to(1);
      check_ball("first_tick", 317, 237, 1, 1);
      run_to(84);
      check_ball("pre_reset", 400, 320, 1, 1);
      #2 rst = 1'b1;
      #1;
      check_ball("async_reset", 316, 236, 1, 1);
      check_val("async_reset_in_play", int'(in_play), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_ball("held_after_reset", 316, 236, 1, 1);
      check_val("held_in_play", int'(in_play), 0);

      // Right paddle out of reach: ball passes the face and scores left
      serve_ball();
      run_to(292);
      check_ball("rface_reach", 608, 416, 1, 0);
      run_to(293);
      check_ball("rface_pass", 609, 415, 1, 0);
      run_to(316);
      check_val("rwall_x", int'(ball_x), 632);
      check_val("rwall_in_play", int'(in_play), 1);
      run_to(317);
      check_val("score_l_pulse", int'(score_l), 1);
      check_val("score_l_no_r", int'(score_r), 0);
      check_val("score_l_in_play", int'(in_play), 0);
      check_val("score_l_x", int'(ball_x), 632);
      @(negedge clk);
      check_val("score_l_one_clk", int'(score_l), 0);
      run_to(320);
      check_val("score_l_frozen", int'(ball_x), 632);
      run_to(321);
      check_ball("score_l_recentre", 316, 236, 1, 0);
      check_val("score_l_idle", int'(in_play), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_ball("reset_again", 316, 236, 1, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Wall bounces, paddle hits, then a left miss
      lpad_y = 10'd150;
      rpad_y = 10'd400;
      serve_ball();
      run_to(235);
      check_ball("bottom_pre", 551, 471, 1, 1);
      run_to(236);
      check_ball("bottom_at", 552, 472, 1, 1);
      run_to(237);
      check_ball("bottom_bounce", 553, 471, 1, 0);
      run_to(292);
      check_ball("rhit_pre", 608, 416, 1, 0);
      run_to(293);
      check_ball("rhit", 607, 415, 0, 0);
      run_to(708);
      check_ball("top_at", 192, 0, 0, 0);
      run_to(709);
      check_ball("top_bounce", 191, 1, 0, 1);
      run_to(875);
      check_ball("lhit_pre", 25, 167, 0, 1);
      run_to(876);
      check_ball("lhit_at", 24, 168, 0, 1);
      run_to(877);
      check_ball("lhit", 25, 169, 1, 1);
      check_val("lhit_no_score", int'(score_r), 0);
      check_val("lhit_in_play", int'(in_play), 1);
      run_to(900);
      rpad_y = 10'd160;
      run_to(1460);
      check_ball("rhit2_pre", 608, 192, 1, 0);
      run_to(1461);
      check_ball("rhit2", 607, 191, 0, 0);
      run_to(1500);
      lpad_y = 10'd0;
      run_to(2044);
      check_ball("lmiss_face", 24, 392, 0, 1);
      run_to(2045);
      check_ball("lmiss_pass", 23, 393, 0, 1);
      run_to(2068);
      check_ball("lwall", 0, 416, 0, 1);
      check_val("lwall_in_play", int'(in_play), 1);
      run_to(2069);
      check_val("score_r_pulse", int'(score_r), 1);
      check_val("score_r_no_l", int'(score_l), 0);
      check_val("score_r_in_play", int'(in_play), 0);
      check_val("score_r_x", int'(ball_x), 0);
      @(negedge clk);
      check_val("score_r_one_clk", int'(score_r), 0);
      run_to(2072);
      check_val("score_r_frozen", int'(ball_x), 0);
      check_val("score_r_hold", int'(in_play), 0);
      run_to(2073);
      check_ball("score_r_recentre", 316, 236, 0, 1);
      check_val("score_r_idle", int'(in_play), 0);
      serve = 1'b0;
      repeat (3) @(negedge clk);
      check_ball("idle_after_score", 316, 236, 0, 1);

      // Long rally with tracking paddles into the right-paddle/bottom corner
      serve_ball();
      for (int k = 1; k <= 17229; k++) begin
         run_to(k);
         lpad_y = 10'(pad_for(ytri(k)));
         rpad_y = 10'(pad_for(ytri(k)));
         if (k == 292)   check_ball("rally_lface", 24, 416, 0, 0);
         if (k == 293)   check_ball("rally_lhit", 25, 415, 1, 0);
         if (k == 17228) check_ball("corner_pre", 608, 472, 1, 1);
         if (k == 17229) begin
            check_ball("corner", 607, 471, 0, 0);
            check_val("corner_in_play", int'(in_play), 1);
            check_val("corner_no_score", int'(score_l), 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
